// File: rtl/captura_func.sv
// captura_func: input-capture stage feeding the 3-bit functionality comparator.
// Synchronizes the switch bank and two push-buttons, debounces the buttons,
// and latches two 3-bit codes in sequence. cmp_valid marks a complete pair.
module captura_func #(
    parameter int DEB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] sw,
    input  logic       btn_ok,
    input  logic       btn_clr,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       E,
    output logic       F,
    output logic       cmp_valid,
    output logic [1:0] estado
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        CAP_A = 2'b00,
        CAP_B = 2'b01,
        READY = 2'b10
    } state_t;

    // Button bit 0 is ok, bit 1 is clear.
    logic [1:0]    btn_raw_s;
    logic [1:0]    btn_meta_r;
    logic [1:0]    btn_sync_r;
    logic [2:0]    sw_meta_r;
    logic [2:0]    sw_sync_r;
    logic [1:0]    db_r;
    logic [1:0]    db_d_r;
    logic [CW-1:0] cnt_r [2];
    logic [1:0]    pulse_s;

    state_t        state_r;
    state_t        state_s;
    logic [2:0]    abc_r;
    logic [2:0]    abc_s;
    logic [2:0]    def_r;
    logic [2:0]    def_s;
    logic          valid_r;
    logic          valid_s;

    assign btn_raw_s = {btn_clr, btn_ok};

    // Two-flop synchronizers for every asynchronous input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_meta_r  <= 3'b000;
            sw_sync_r  <= 3'b000;
            btn_meta_r <= 2'b00;
            btn_sync_r <= 2'b00;
        end else begin
            sw_meta_r  <= sw;
            sw_sync_r  <= sw_meta_r;
            btn_meta_r <= btn_raw_s;
            btn_sync_r <= btn_meta_r;
        end
    end

    // Debouncers: a level is accepted after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_r     <= 2'b00;
            db_d_r   <= 2'b00;
            cnt_r[0] <= CNT_ZERO;
            cnt_r[1] <= CNT_ZERO;
        end else begin
            db_d_r <= db_r;
            for (int i = 0; i < 2; i++) begin
                if (btn_sync_r[i] == db_r[i]) begin
                    cnt_r[i] <= CNT_ZERO;
                end else if (cnt_r[i] == CNT_LAST) begin
                    db_r[i]  <= btn_sync_r[i];
                    cnt_r[i] <= CNT_ZERO;
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_ONE;
                end
            end
        end
    end

    // Rising edge of the accepted level: one pulse per press, none while held.
    assign pulse_s = db_r & ~db_d_r;

    // FSM and output register update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= CAP_A;
            abc_r   <= 3'b000;
            def_r   <= 3'b000;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            abc_r   <= abc_s;
            def_r   <= def_s;
            valid_r <= valid_s;
        end
    end

    // Next-state logic; a clear pulse overrides any simultaneous ok pulse.
    always_comb begin
        state_s = state_r;
        abc_s   = abc_r;
        def_s   = def_r;
        valid_s = valid_r;
        if (pulse_s[1]) begin
            state_s = CAP_A;
            abc_s   = 3'b000;
            def_s   = 3'b000;
            valid_s = 1'b0;
        end else begin
            case (state_r)
                CAP_A: begin
                    if (pulse_s[0]) begin
                        abc_s   = sw_sync_r;
                        state_s = CAP_B;
                    end else begin
                        state_s = CAP_A;
                    end
                end
                CAP_B: begin
                    if (pulse_s[0]) begin
                        def_s   = sw_sync_r;
                        valid_s = 1'b1;
                        state_s = READY;
                    end else begin
                        state_s = CAP_B;
                    end
                end
                READY: begin
                    if (pulse_s[0]) begin
                        abc_s   = sw_sync_r;
                        def_s   = 3'b000;
                        valid_s = 1'b0;
                        state_s = CAP_B;
                    end else begin
                        state_s = READY;
                    end
                end
                default: begin
                    state_s = CAP_A;
                    abc_s   = 3'b000;
                    def_s   = 3'b000;
                    valid_s = 1'b0;
                end
            endcase
        end
    end

    assign A         = abc_r[2];
    assign B         = abc_r[1];
    assign C         = abc_r[0];
    assign D         = def_r[2];
    assign E         = def_r[1];
    assign F         = def_r[0];
    assign cmp_valid = valid_r;
    assign estado    = state_r;

endmodule

// File: tb/tb_captura_func.sv
// Testbench for captura_func with DEB_CYCLES=4: directed scenarios plus a
// randomized phase, every cycle compared against a window-based reference model.
module tb_captura_func;

    localparam int DEB = 4;

    logic       clk;
    logic       reset_n;
    logic [2:0] sw;
    logic       btn_ok;
    logic       btn_clr;
    logic       A, B, C, D, E, F;
    logic       cmp_valid;
    logic [1:0] estado;

    int vectors;
    int miscompares;

    captura_func #(.DEB_CYCLES(DEB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sw        (sw),
        .btn_ok    (btn_ok),
        .btn_clr   (btn_clr),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .E         (E),
        .F         (F),
        .cmp_valid (cmp_valid),
        .estado    (estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: samples seen at each edge since reset release.
    bit       hist_ok[$];
    bit       hist_clr[$];
    bit [2:0] hist_sw[$];
    int       n_edge;
    bit       m_db[2];
    bit       m_pulse[2];
    bit [2:0] m_abc;
    bit [2:0] m_def;
    bit       m_valid;
    bit [1:0] m_st;

    function automatic bit samp(int b, int idx);
        if (idx < 0) return 1'b0;
        if (b == 0) return hist_ok[idx];
        return hist_clr[idx];
    endfunction

    function automatic logic [8:0] exp_vec();
        return {m_abc, m_def, m_valid, m_st};
    endfunction

    function automatic logic [8:0] dut_vec();
        return {A, B, C, D, E, F, cmp_valid, estado};
    endfunction

    task automatic model_reset();
        hist_ok = {};
        hist_clr = {};
        hist_sw = {};
        n_edge = 0;
        m_db[0] = 1'b0; m_db[1] = 1'b0;
        m_pulse[0] = 1'b0; m_pulse[1] = 1'b0;
        m_abc = 3'b000; m_def = 3'b000; m_valid = 1'b0; m_st = 2'b00;
    endtask

    // One clock edge of the model: the switch value used is the one seen two
    // edges ago; an accepted level flips once the last DEB synchronized samples
    // all disagree with it, and a rising flip acts on the FSM one edge later.
    task automatic model_edge(input bit ok, input bit clr, input bit [2:0] s);
        bit [2:0] ss;
        bit flip;
        ss = (n_edge >= 2) ? hist_sw[n_edge-2] : 3'b000;
        if (m_pulse[1]) begin
            m_abc = 3'b000; m_def = 3'b000; m_valid = 1'b0; m_st = 2'b00;
        end else if (m_pulse[0]) begin
            if (m_st == 2'b00) begin
                m_abc = ss; m_st = 2'b01;
            end else if (m_st == 2'b01) begin
                m_def = ss; m_valid = 1'b1; m_st = 2'b10;
            end else begin
                m_abc = ss; m_def = 3'b000; m_valid = 1'b0; m_st = 2'b01;
            end
        end
        hist_ok.push_back(ok);
        hist_clr.push_back(clr);
        hist_sw.push_back(s);
        for (int b = 0; b < 2; b++) begin
            flip = 1'b1;
            for (int j = 0; j < DEB; j++) begin
                if (samp(b, n_edge - 2 - j) == m_db[b]) flip = 1'b0;
            end
            m_pulse[b] = 1'b0;
            if (flip) begin
                m_db[b] = ~m_db[b];
                m_pulse[b] = m_db[b];
            end
        end
        n_edge++;
    endtask

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Advance one clock: sample inputs, step the model, compare at the falling edge.
    task automatic tick();
        bit r_ok;
        bit r_clr;
        bit [2:0] r_sw;
        bit r_rst;
        r_ok = btn_ok; r_clr = btn_clr; r_sw = sw; r_rst = reset_n;
        @(posedge clk);
        if (!r_rst) model_reset();
        else model_edge(r_ok, r_clr, r_sw);
        @(negedge clk);
        chk("cycle", dut_vec(), exp_vec());
    endtask

    task automatic press(input bit ok, input bit clr, input logic [2:0] s, input int hi);
        sw = s;
        tick(); tick();
        btn_ok = ok; btn_clr = clr;
        repeat (hi) tick();
        btn_ok = 1'b0; btn_clr = 1'b0;
        repeat (DEB + 4) tick();
    endtask

    int ok_run;
    int clr_run;

    initial begin
        vectors = 0;
        miscompares = 0;
        model_reset();
        reset_n = 1'b0; sw = 3'b000; btn_ok = 1'b0; btn_clr = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        chk("reset", dut_vec(), 9'b000_000_0_00);

        // Nominal pair with exact latency
        sw = 3'b101;
        tick(); tick();
        btn_ok = 1'b1;
        tick();
        repeat (5) tick();
        chk("latency_before", dut_vec(), 9'b000_000_0_00);
        tick();
        chk("latency_capture", dut_vec(), 9'b101_000_0_01);
        repeat (3) tick();
        btn_ok = 1'b0;
        repeat (8) tick();
        press(1'b1, 1'b0, 3'b101, 10);
        chk("pair_done", dut_vec(), 9'b101_101_1_10);

        // Bounce rejection, then a long hold yields a single capture
        repeat (5) begin
            btn_ok = 1'b1; repeat (3) tick();
            btn_ok = 1'b0; repeat (2) tick();
        end
        repeat (8) tick();
        chk("bounce_reject", dut_vec(), 9'b101_101_1_10);
        press(1'b1, 1'b0, 3'b011, 20);
        chk("bounce_hold", dut_vec(), 9'b011_000_0_01);

        // Restart from READY
        press(1'b0, 1'b1, 3'b000, 8);
        chk("clear_cap_b", dut_vec(), 9'b000_000_0_00);
        press(1'b1, 1'b0, 3'b101, 8);
        press(1'b1, 1'b0, 3'b011, 8);
        chk("ready_101011", dut_vec(), 9'b101_011_1_10);
        press(1'b1, 1'b0, 3'b110, 8);
        chk("restart", dut_vec(), 9'b110_000_0_01);
        press(1'b1, 1'b0, 3'b110, 8);
        chk("restart_done", dut_vec(), 9'b110_110_1_10);

        // Clear priority over a simultaneous ok, and clear alone from READY
        press(1'b1, 1'b0, 3'b010, 8);
        chk("cap_b_010", dut_vec(), 9'b010_000_0_01);
        press(1'b1, 1'b1, 3'b111, 8);
        chk("clr_priority", dut_vec(), 9'b000_000_0_00);
        press(1'b1, 1'b0, 3'b001, 8);
        press(1'b1, 1'b0, 3'b100, 8);
        chk("ready_001100", dut_vec(), 9'b001_100_1_10);
        press(1'b0, 1'b1, 3'b100, 8);
        chk("clr_from_ready", dut_vec(), 9'b000_000_0_00);

        // Switch isolation in READY
        press(1'b1, 1'b0, 3'b111, 8);
        press(1'b1, 1'b0, 3'b010, 8);
        for (int v = 0; v < 8; v++) begin
            sw = 3'(v);
            repeat (3) tick();
            chk("sw_sweep", dut_vec(), 9'b111_010_1_10);
        end

        // Randomized buttons and switches against the model
        ok_run = 0;
        clr_run = 0;
        for (int c = 0; c < 800; c++) begin
            sw = 3'($urandom_range(0, 7));
            if (ok_run == 0) begin
                btn_ok = 1'($urandom_range(0, 1));
                ok_run = $urandom_range(1, 10);
            end
            if (clr_run == 0) begin
                btn_clr = ($urandom_range(0, 5) == 0);
                clr_run = $urandom_range(1, 10);
            end
            ok_run--;
            clr_run--;
            tick();
        end
        btn_ok = 1'b0; btn_clr = 1'b0;
        repeat (10) tick();

        // Reset mid-press, button still held at release
        press(1'b0, 1'b1, 3'b000, 8);
        press(1'b1, 1'b0, 3'b111, 8);
        chk("pre_reset", dut_vec(), 9'b111_000_0_01);
        btn_ok = 1'b1;
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        chk("async_reset", dut_vec(), 9'b000_000_0_00);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (6) tick();
        chk("held_after_reset_wait", dut_vec(), 9'b000_000_0_00);
        tick();
        chk("held_after_reset_capture", dut_vec(), 9'b111_000_0_01);
        btn_ok = 1'b0;
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
